// File: rtl/sn_frame_decoder_if.sv
// Bundles the stream-in and result-out signals of the stochastic frame decoder.
// Latency: none, wires only.
// Backpressure: sn_ready gates the input stream; out_ready holds the result.
interface sn_frame_decoder_if #(
  parameter int LANES      = 16,
  parameter int FRAME_LOG2 = 10,
  parameter int OUT_WIDTH  = 11
);
  logic                  start;
  logic [LANES-1:0]      sn_in;
  logic                  sn_valid;
  logic                  sn_last;
  logic                  sn_ready;
  logic [OUT_WIDTH-1:0]  bin_out;
  logic [FRAME_LOG2:0]   beats_out;
  logic                  sat;
  logic                  out_valid;
  logic                  out_ready;
  logic                  busy;

  // Environment side: produces the bitstream, consumes the result.
  modport master (
    output start, sn_in, sn_valid, sn_last, out_ready,
    input  sn_ready, bin_out, beats_out, sat, out_valid, busy
  );

  // Decoder side.
  modport slave (
    input  start, sn_in, sn_valid, sn_last, out_ready,
    output sn_ready, bin_out, beats_out, sat, out_valid, busy
  );
endinterface

// File: rtl/sn_frame_decoder.sv
// Counts ones in a LANES-wide stochastic bitstream over one frame and returns the count.
// Latency: result valid the cycle after the final accepted beat.
// Backpressure: sn_ready only in ACC; result held in DONE until out_ready.
module sn_frame_decoder #(
  parameter int LANES      = 16,
  parameter int FRAME_LOG2 = 10,
  parameter int OUT_WIDTH  = 11
) (
  input  logic             clk,
  input  logic             rst,
  sn_frame_decoder_if.slave bus
);

  // Accumulator and beat counter both span 0..2**FRAME_LOG2, so neither can wrap.
  localparam int AW      = FRAME_LOG2 + 1;
  localparam int LV      = $clog2(LANES);
  localparam int CW      = LV + 1;
  localparam int NBEATS  = (2 ** FRAME_LOG2) / LANES;
  localparam logic [AW-1:0] LAST_BEAT = AW'(NBEATS - 1);

  // Comparison width covers both the accumulator and the output range, so the
  // saturation test works whether OUT_WIDTH is narrower or wider than acc.
  localparam int CMPW = ((AW > OUT_WIDTH) ? AW : OUT_WIDTH) + 1;
  localparam logic [CMPW-1:0] MAX_X = CMPW'({OUT_WIDTH{1'b1}});

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q;
  logic [AW-1:0]        acc_q;
  logic [AW-1:0]        beat_ctr_q;
  logic                 sn_ready_q;
  logic [OUT_WIDTH-1:0] bin_q;
  logic [AW-1:0]        beats_q;
  logic                 sat_q;
  logic                 out_valid_q;
  logic                 busy_q;

  logic [CW-1:0]        pop;
  logic [AW-1:0]        acc_d;
  logic [AW-1:0]        beat_ctr_d;
  logic [CMPW-1:0]      sum_x;
  logic                 sat_d;
  logic [OUT_WIDTH-1:0] bin_d;
  logic                 accept;
  logic                 final_beat;

  // Popcount as a balanced adder tree: level 0 holds the lanes, each further
  // level sums adjacent pairs of the level below.
  for (genvar l = 0; l <= LV; l++) begin : g_lvl
    localparam int N = LANES >> l;
    logic [CW-1:0] s [N];
    for (genvar k = 0; k < N; k++) begin : g_node
      if (l == 0) begin : g_leaf
        assign s[k] = CW'(bus.sn_in[k]);
      end else begin : g_add
        assign s[k] = g_lvl[l-1].s[2*k] + g_lvl[l-1].s[2*k+1];
      end
    end
  end

  assign pop = g_lvl[LV].s[0];

  // Next accumulator/counter values and the clipped result for the current beat.
  always_comb begin
    acc_d      = acc_q + AW'(pop);
    beat_ctr_d = beat_ctr_q + AW'(1);
    sum_x      = CMPW'(acc_d);
    sat_d      = (sum_x > MAX_X);
    bin_d      = sat_d ? {OUT_WIDTH{1'b1}} : sum_x[OUT_WIDTH-1:0];
    accept     = bus.sn_valid & sn_ready_q;
    final_beat = bus.sn_last | (beat_ctr_q == LAST_BEAT);
  end

  // Frame control FSM; every output is registered here.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      beat_ctr_q  <= '0;
      sn_ready_q  <= 1'b0;
      bin_q       <= '0;
      beats_q     <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_q    <= S_ACC;
            acc_q      <= '0;
            beat_ctr_q <= '0;
            sn_ready_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end

        S_ACC: begin
          // start is deliberately ignored here; idle sn_valid cycles just stall.
          if (accept) begin
            acc_q      <= acc_d;
            beat_ctr_q <= beat_ctr_d;
            if (final_beat) begin
              state_q     <= S_DONE;
              sn_ready_q  <= 1'b0;
              bin_q       <= bin_d;
              sat_q       <= sat_d;
              beats_q     <= beat_ctr_d;
              out_valid_q <= 1'b1;
            end
          end
        end

        S_DONE: begin
          // Result registers stay untouched until the next frame completes.
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            if (bus.start) begin
              state_q    <= S_ACC;
              acc_q      <= '0;
              beat_ctr_q <= '0;
              sn_ready_q <= 1'b1;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end
        end

        default: begin
          state_q     <= S_IDLE;
          sn_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sn_ready  = sn_ready_q;
  assign bus.bin_out   = bin_q;
  assign bus.beats_out = beats_q;
  assign bus.sat       = sat_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;

endmodule
